// File: rtl/load_store_unit.sv
// load_store_unit
//
// Bridges the execute stage to a word-wide data memory. It handles byte,
// halfword and word loads and stores:
//   - Loads return the selected lane, sign- or zero-extended.
//   - Sub-word stores are a two-cycle read-modify-write, because the memory
//     only writes whole words.
//   - Misaligned requests finish with a done+fault pulse and never access
//     memory.
//
// Optional feature (compile-time macro LSU_RANGE_CHECK_EN):
//   defined   - any set bit in addr[31:ADDR_W+2] also faults.
//   undefined - the upper address bits are ignored, so accesses wrap.
//
// Ports
//   clk, rst          clock; asynchronous active-high reset
//   req               request strobe, sampled only while idle
//   we                1 = store, 0 = load
//   size              00 byte, 01 half, 10/11 word
//   unsigned_ld       1 = zero-extend loads
//   addr              byte address
//   wdata             store data, sub-word value in the low bits
//   busy              high whenever the FSM is not idle
//   done, fault       one-cycle completion pulse / rejected-request pulse
//   rdata             last completed load result
//   dm_ena/dm_w/dm_r  memory strobes
//   dm_addr           memory word index
//   dm_wdata          memory write data
//   dm_rdata          combinational memory read data
module load_store_unit #(
  parameter int ADDR_W = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        we,
  input  logic [1:0]  size,
  input  logic        unsigned_ld,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic        fault,
  output logic [31:0] rdata,
  output logic        dm_ena,
  output logic        dm_w,
  output logic        dm_r,
  output logic [31:0] dm_addr,
  output logic [31:0] dm_wdata,
  input  logic [31:0] dm_rdata
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_STORE,
    S_RMW_RD,
    S_RMW_WR,
    S_FIN
  } state_t;

  state_t      state_q, state_d;
  logic [1:0]  size_q, size_d;
  logic        uns_q, uns_d;
  logic [1:0]  lane_q, lane_d;    // only the low address bits matter after acceptance
  logic [15:0] wdata_q, wdata_d;  // only the sub-word part is merged later
  logic [31:0] rdata_q, rdata_d;
  logic [31:0] dm_addr_q, dm_addr_d;
  logic [31:0] dm_wdata_q, dm_wdata_d;  // also serves as the RMW merge register
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        fault_q, fault_d;
  logic        dm_ena_q, dm_ena_d;
  logic        dm_w_q, dm_w_d;
  logic        dm_r_q, dm_r_d;

  logic        misaligned;
  logic        addr_hi_nz;
  logic        range_fault;
  logic [31:0] word_idx;
  logic [31:0] byte_shifted;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_ext;
  logic [31:0] merged;

  // Request checks are done on the live inputs at acceptance.
  assign misaligned = (size == 2'b01 && addr[0]) || (size[1] && addr[1:0] != 2'b00);
  assign addr_hi_nz = |addr[31:ADDR_W+2];
  assign word_idx   = {{(32-ADDR_W){1'b0}}, addr[ADDR_W+1:2]};

`ifdef LSU_RANGE_CHECK_EN
  assign range_fault = addr_hi_nz;
`else
  // Upper bits are deliberately ignored; the address wraps.
  logic unused_addr_hi;
  assign range_fault    = 1'b0;
  assign unused_addr_hi = addr_hi_nz;
`endif

  // Load lane extraction from the memory word, little-endian.
  assign byte_shifted = dm_rdata >> {lane_q, 3'b000};
  assign ld_byte      = byte_shifted[7:0];
  assign ld_half      = lane_q[1] ? dm_rdata[31:16] : dm_rdata[15:0];

  always_comb begin
    case (size_q)
      2'b00:   ld_ext = {{24{~uns_q & ld_byte[7]}}, ld_byte};
      2'b01:   ld_ext = {{16{~uns_q & ld_half[15]}}, ld_half};
      default: ld_ext = dm_rdata;
    endcase
  end

  // Store merge: replace the selected lane of the word just read.
  always_comb begin
    merged = dm_rdata;
    if (size_q == 2'b00) begin
      merged[{lane_q, 3'b000} +: 8] = wdata_q[7:0];
    end else if (lane_q[1]) begin
      merged[31:16] = wdata_q;
    end else begin
      merged[15:0] = wdata_q;
    end
  end

  always_comb begin
    state_d    = state_q;
    size_d     = size_q;
    uns_d      = uns_q;
    lane_d     = lane_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    dm_addr_d  = dm_addr_q;
    dm_wdata_d = dm_wdata_q;
    fault_d    = 1'b0;
    dm_ena_d   = 1'b0;
    dm_w_d     = 1'b0;
    dm_r_d     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (req) begin
          size_d  = size;
          uns_d   = unsigned_ld;
          lane_d  = addr[1:0];
          wdata_d = wdata[15:0];
          if (misaligned || range_fault) begin
            // Rejected requests skip memory entirely.
            state_d = S_FIN;
            fault_d = 1'b1;
          end else if (!we) begin
            state_d   = S_LOAD;
            dm_addr_d = word_idx;
            dm_ena_d  = 1'b1;
            dm_r_d    = 1'b1;
          end else if (size[1]) begin
            state_d    = S_STORE;
            dm_addr_d  = word_idx;
            dm_wdata_d = wdata;
            dm_ena_d   = 1'b1;
            dm_w_d     = 1'b1;
          end else begin
            state_d   = S_RMW_RD;
            dm_addr_d = word_idx;
            dm_ena_d  = 1'b1;
            dm_r_d    = 1'b1;
          end
        end
      end
      S_LOAD: begin
        rdata_d = ld_ext;
        state_d = S_FIN;
      end
      S_STORE: begin
        state_d = S_FIN;
      end
      S_RMW_RD: begin
        dm_wdata_d = merged;
        dm_ena_d   = 1'b1;
        dm_w_d     = 1'b1;
        state_d    = S_RMW_WR;
      end
      S_RMW_WR: begin
        state_d = S_FIN;
      end
      S_FIN: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Outputs are registered, so they are derived from the next state.
    done_d = (state_d == S_FIN);
    busy_d = (state_d != S_IDLE);
  end

  // An asynchronous reset drops the write strobe immediately, so an aborted
  // RMW can never write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      size_q     <= 2'b00;
      uns_q      <= 1'b0;
      lane_q     <= 2'b00;
      wdata_q    <= 16'h0000;
      rdata_q    <= 32'h0;
      dm_addr_q  <= 32'h0;
      dm_wdata_q <= 32'h0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      fault_q    <= 1'b0;
      dm_ena_q   <= 1'b0;
      dm_w_q     <= 1'b0;
      dm_r_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      size_q     <= size_d;
      uns_q      <= uns_d;
      lane_q     <= lane_d;
      wdata_q    <= wdata_d;
      rdata_q    <= rdata_d;
      dm_addr_q  <= dm_addr_d;
      dm_wdata_q <= dm_wdata_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      fault_q    <= fault_d;
      dm_ena_q   <= dm_ena_d;
      dm_w_q     <= dm_w_d;
      dm_r_q     <= dm_r_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign fault    = fault_q;
  assign rdata    = rdata_q;
  assign dm_ena   = dm_ena_q;
  assign dm_w     = dm_w_q;
  assign dm_r     = dm_r_q;
  assign dm_addr  = dm_addr_q;
  assign dm_wdata = dm_wdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit
//
// Directed and random load/store traffic against a byte-lane reference model
// of memory and load results. The bench also owns the data memory behind the
// unit.
module tb_load_store_unit;
  localparam int ADDR_W = 10;
  localparam int DEPTH  = 1 << ADDR_W;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req = 1'b0;
  logic        we = 1'b0;
  logic [1:0]  size = 2'b00;
  logic        unsigned_ld = 1'b0;
  logic [31:0] addr = 32'h0;
  logic [31:0] wdata = 32'h0;
  logic        busy, done, fault;
  logic [31:0] rdata;
  logic        dm_ena, dm_w, dm_r;
  logic [31:0] dm_addr, dm_wdata, dm_rdata;

  logic [31:0] mem     [DEPTH];
  logic [31:0] ref_mem [DEPTH];
  logic              init_en = 1'b1;
  logic              bd_we   = 1'b0;
  logic [ADDR_W-1:0] bd_idx  = '0;
  logic [31:0]       bd_data = 32'h0;
  int unsigned rd_cnt = 0;
  int unsigned wr_cnt = 0;
  int          cmp_cnt = 0;
  int          err_cnt = 0;
  logic [31:0] exp_rdata = 32'h0;
  logic        unused_tb;

  load_store_unit #(.ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst), .req(req), .we(we), .size(size),
    .unsigned_ld(unsigned_ld), .addr(addr), .wdata(wdata),
    .busy(busy), .done(done), .fault(fault), .rdata(rdata),
    .dm_ena(dm_ena), .dm_w(dm_w), .dm_r(dm_r), .dm_addr(dm_addr),
    .dm_wdata(dm_wdata), .dm_rdata(dm_rdata)
  );

  always #5 clk = ~clk;

  assign dm_rdata  = mem[dm_addr[ADDR_W-1:0]];
  assign unused_tb = ^dm_addr[31:ADDR_W];

  function automatic logic [31:0] init_word(input int i);
    return (32'(i) * 32'h9E3779B1) ^ 32'h5A5A0F0F;
  endfunction

  always @(posedge clk) begin
    if (init_en) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= init_word(i);
    end else if (dm_ena && dm_w) begin
      mem[dm_addr[ADDR_W-1:0]] <= dm_wdata;
    end else if (bd_we) begin
      mem[bd_idx] <= bd_data;
    end
  end

  always @(posedge clk) begin
    if (dm_ena && dm_w) wr_cnt <= wr_cnt + 1;
    if (dm_ena && dm_r) rd_cnt <= rd_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    cmp_cnt++;
    assert (obs === exp) else begin
      err_cnt++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference load: pick the lane arithmetically, then sign-extend by
  // subtracting the lane range when the top bit of the lane is set.
  function automatic logic [31:0] ref_load(input logic [31:0] word, input logic [1:0] sz,
                                           input logic u, input logic [1:0] off);
    logic [31:0] v;
    if (sz == 2'd0) begin
      v = (word >> (8 * off)) & 32'hFF;
      if (!u && v >= 32'd128) v = v - 32'd256;
    end else if (sz == 2'd1) begin
      v = (word >> (8 * (off & 2'd2))) & 32'hFFFF;
      if (!u && v >= 32'd32768) v = v - 32'd65536;
    end else begin
      v = word;
    end
    return v;
  endfunction

  function automatic logic [31:0] ref_store(input logic [31:0] word, input logic [1:0] sz,
                                            input logic [1:0] off, input logic [31:0] d);
    logic [31:0] mask;
    int          sh;
    if (sz[1]) return d;
    mask = (sz == 2'd0) ? 32'hFF : 32'hFFFF;
    sh   = (sz == 2'd0) ? 8 * int'(off) : 8 * int'(off & 2'd2);
    return (word & ~(mask << sh)) | ((d & mask) << sh);
  endfunction

  task automatic set_word(input int idx, input logic [31:0] val);
    @(negedge clk);
    bd_we   = 1'b1;
    bd_idx  = ADDR_W'(idx);
    bd_data = val;
    @(posedge clk);
    #1 bd_we = 1'b0;
    ref_mem[idx] = val;
  endtask

  task automatic do_op(input string tag, input logic w, input logic [1:0] sz, input logic u,
                       input logic [31:0] a, input logic [31:0] d, input bit hold_req);
    int          idx;
    bit          flt;
    int          exp_lat, exp_rd, exp_wr, lat;
    int unsigned rd0, wr0;

    idx = int'((a >> 2) & 32'(DEPTH - 1));
    flt = (sz == 2'b01 && a[0]) || (sz[1] && a[1:0] != 2'b00);
`ifdef LSU_RANGE_CHECK_EN
    if (a >= 32'(4 * DEPTH)) flt = 1'b1;
`endif
    exp_rd = 0;
    exp_wr = 0;
    if (flt) begin
      exp_lat = 1;
    end else if (!w) begin
      exp_lat   = 2;
      exp_rd    = 1;
      exp_rdata = ref_load(ref_mem[idx], sz, u, a[1:0]);
    end else if (sz[1]) begin
      exp_lat      = 2;
      exp_wr       = 1;
      ref_mem[idx] = d;
    end else begin
      exp_lat      = 3;
      exp_rd       = 1;
      exp_wr       = 1;
      ref_mem[idx] = ref_store(ref_mem[idx], sz, a[1:0], d);
    end

    @(negedge clk);
    req = 1'b1; we = w; size = sz; unsigned_ld = u; addr = a; wdata = d;
    rd0 = rd_cnt;
    wr0 = wr_cnt;
    @(posedge clk);
    #1;
    // Scramble the inputs so that only the latched copy can be used.
    if (!hold_req) req = 1'b0;
    we = $urandom_range(0, 1);
    size = 2'($urandom_range(0, 3));
    unsigned_ld = $urandom_range(0, 1);
    addr = $urandom;
    wdata = $urandom;
    lat = 0;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      if (c == 1) chk({tag, ".busy"}, 32'(busy), 32'd1);
      if (done === 1'b1) begin
        lat = c;
        break;
      end
    end
    req = 1'b0;
    chk({tag, ".latency"}, 32'(lat), 32'(exp_lat));
    chk({tag, ".fault"}, 32'(fault), 32'(flt));
    chk({tag, ".rdata"}, rdata, exp_rdata);
    chk({tag, ".reads"}, rd_cnt - rd0, 32'(exp_rd));
    chk({tag, ".writes"}, wr_cnt - wr0, 32'(exp_wr));
    chk({tag, ".mem"}, mem[idx], ref_mem[idx]);
    $display("op %s we=%0b size=%0d uns=%0b addr=%h wdata=%h lat=%0d fault=%0b rdata=%h",
             tag, w, sz, u, a, d, lat, fault, rdata);
    @(negedge clk);
    chk({tag, ".idle"}, {30'd0, busy, done}, 32'd0);
  endtask

  initial begin
    logic [31:0] ra;
    logic [1:0]  rs;

    for (int i = 0; i < DEPTH; i++) ref_mem[i] = init_word(i);

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst.busy", 32'(busy), 32'd0);
    chk("rst.done", 32'(done), 32'd0);
    chk("rst.fault", 32'(fault), 32'd0);
    chk("rst.rdata", rdata, 32'd0);
    chk("rst.strobes", {29'd0, dm_ena, dm_w, dm_r}, 32'd0);
    chk("rst.dm_addr", dm_addr, 32'd0);
    chk("rst.dm_wdata", dm_wdata, 32'd0);
    init_en = 1'b0;
    rst = 1'b0;
    @(negedge clk);

    // Word store then load
    do_op("st_word", 1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF, 1'b0);
    chk("st_word.dm_addr", dm_addr, 32'd4);
    do_op("ld_word", 1'b0, 2'd2, 1'b1, 32'h10, 32'h0, 1'b0);
    chk("ld_word.value", rdata, 32'hDEADBEEF);

    // Byte loads, signed and unsigned
    set_word(4, 32'h12348056);
    do_op("ld_byte_s", 1'b0, 2'd0, 1'b0, 32'h11, 32'h0, 1'b0);
    chk("ld_byte_s.value", rdata, 32'hFFFFFF80);
    do_op("ld_byte_u", 1'b0, 2'd0, 1'b1, 32'h11, 32'h0, 1'b0);
    chk("ld_byte_u.value", rdata, 32'h00000080);

    // Halfword store merge
    set_word(4, 32'h11223344);
    do_op("st_half", 1'b1, 2'd1, 1'b0, 32'h12, 32'h0000ABCD, 1'b0);
    chk("st_half.value", mem[4], 32'hABCD3344);

    // Misaligned half store, misaligned word load, size 11 as word
    do_op("st_half_mis", 1'b1, 2'd1, 1'b0, 32'h13, 32'h00005555, 1'b0);
    do_op("ld_word_mis", 1'b0, 2'd2, 1'b0, 32'h102, 32'h0, 1'b0);
    do_op("ld_size3", 1'b0, 2'd3, 1'b0, 32'h20, 32'h0, 1'b0);

    // req held high while busy must not start a second operation
    do_op("ld_hold", 1'b0, 2'd1, 1'b0, 32'h22, 32'h0, 1'b1);

    // Out-of-range address: faults with the check, wraps to word 0 without
    do_op("ld_range", 1'b0, 2'd2, 1'b0, 32'h00001000, 32'h0, 1'b0);

    // Reset during RMW_RD of a byte store
    set_word(8, 32'hCAFEF00D);
    @(negedge clk);
    req = 1'b1; we = 1'b1; size = 2'd0; unsigned_ld = 1'b0; addr = 32'h21; wdata = 32'h77;
    @(posedge clk);
    #1 req = 1'b0;
    chk("rmw_rst.in_rd", {29'd0, dm_ena, dm_w, dm_r}, 32'd5);
    #1 rst = 1'b1;
    #1;
    exp_rdata = 32'h0;
    chk("rmw_rst.busy", 32'(busy), 32'd0);
    chk("rmw_rst.outs", {28'd0, done, fault, dm_ena, dm_w}, 32'd0);
    chk("rmw_rst.dm_r", 32'(dm_r), 32'd0);
    chk("rmw_rst.rdata", rdata, 32'd0);
    chk("rmw_rst.dm_addr", dm_addr, 32'd0);
    chk("rmw_rst.dm_wdata", dm_wdata, 32'd0);
    begin
      int unsigned wr0;
      wr0 = wr_cnt;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      repeat (2) @(negedge clk);
      chk("rmw_rst.writes", wr_cnt - wr0, 32'd0);
      chk("rmw_rst.mem", mem[8], 32'hCAFEF00D);
    end
    $display("op rmw_rst byte store at 0x21 aborted by reset, word 8=%h", mem[8]);

    // Random traffic
    for (int n = 0; n < 150; n++) begin
      rs = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 3) == 0) ra = $urandom;
      else ra = 32'($urandom_range(0, 4 * DEPTH - 1));
      if ($urandom_range(0, 9) < 7) begin
        if (rs[1]) ra[1:0] = 2'b00;
        else if (rs == 2'd1) ra[0] = 1'b0;
      end
      do_op($sformatf("rnd%0d", n), 1'($urandom_range(0, 1)), rs,
            1'($urandom_range(0, 1)), ra, $urandom, 1'($urandom_range(0, 1)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

endmodule
